// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, requests the synchronous instruction SRAM,
// buffers the returned instruction across decode stalls and redirects on branches.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1c000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [32:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        fs_valid;
  logic [31:0] fs_pc;
  logic        req_d;
  logic [31:0] inst_buf;
  logic        buf_valid;

  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic        to_fs_valid;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic [31:0] fs_inst;

  assign br_taken    = br_bus[32];
  assign br_target   = br_bus[31:0];
  assign seq_pc      = fs_pc + 32'd4;
  assign nextpc      = br_taken ? br_target : seq_pc;
  assign to_fs_valid = ~reset;
  assign fs_ready_go = 1'b1;

  // A taken branch forces fs open so the redirect request goes out regardless of decode stalls.
  assign fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken;

  assign inst_sram_en    = to_fs_valid & fs_allowin;
  assign inst_sram_we    = '0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = '0;

  assign fs_inst        = buf_valid ? inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
  assign fs_to_ds_bus   = {fs_pc, fs_inst};

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid <= 1'b0;
      fs_pc    <= RESET_PC - 32'd4;
      req_d    <= 1'b0;
    end else if (fs_allowin) begin
      fs_valid <= to_fs_valid;
      fs_pc    <= nextpc;
      req_d    <= inst_sram_en;
    end else begin
      req_d    <= 1'b0;
    end
  end

  // rdata is only valid on the first stall cycle (req_d), so it is captured exactly once.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_buf  <= '0;
      buf_valid <= 1'b0;
    end else if (br_taken || (fs_valid && ds_allowin)) begin
      buf_valid <= 1'b0;
    end else if (fs_valid && req_d && !ds_allowin) begin
      inst_buf  <= inst_sram_rdata;
      buf_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: scoreboard of expected {pc, inst} deliveries plus
// per-cycle checks of the SRAM request and the decode handshake.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        ds_allowin;
  logic [32:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int unsigned total = 0;
  int unsigned bad   = 0;
  logic [63:0] sb[$];

  if_stage #(.RESET_PC(32'h1c000000)) dut (
    .clk             (clk),
    .reset           (reset),
    .ds_allowin      (ds_allowin),
    .br_bus          (br_bus),
    .fs_to_ds_valid  (fs_to_ds_valid),
    .fs_to_ds_bus    (fs_to_ds_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_we    (inst_sram_we),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM returns the request address as data; garbage when not enabled.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= inst_sram_addr;
    else              inst_sram_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic allow, input logic bt, input logic [31:0] tgt);
    reset      = rst;
    ds_allowin = allow;
    br_bus     = {bt, tgt};
    #1;
  endtask

  task automatic req(input string tag, input logic en, input logic [31:0] addr, input logic push);
    check({tag, "_en"}, {63'b0, inst_sram_en}, {63'b0, en});
    if (en) check({tag, "_addr"}, {32'b0, inst_sram_addr}, {32'b0, addr});
    if (push) sb.push_back({addr, addr});
  endtask

  task automatic vld(input string tag, input logic v);
    check({tag, "_valid"}, {63'b0, fs_to_ds_valid}, {63'b0, v});
  endtask

  // Any accepted handshake must match the next scoreboard entry.
  task automatic tick();
    if (fs_to_ds_valid && ds_allowin) begin
      if (sb.size() == 0) check("sb_extra", {63'b0, fs_to_ds_valid}, 64'h0);
      else                check("deliver", fs_to_ds_bus, sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; ds_allowin = 1'b1; br_bus = '0;
    @(posedge clk); @(negedge clk);
    drive(1, 1, 0, 0);
    vld("rst", 0);
    req("rst", 0, 0, 0);
    check("rst_pc", {32'b0, fs_to_ds_bus[63:32]}, {32'b0, 32'h1bfffffc});
    check("rst_we", {60'b0, inst_sram_we}, 64'h0);
    check("rst_wdata", {32'b0, inst_sram_wdata}, 64'h0);
    tick();

    // Streaming fetch
    drive(0, 1, 0, 0); vld("c0", 0); req("c0", 1, 32'h1c000000, 1); tick();
    drive(0, 1, 0, 0); vld("c1", 1); req("c1", 1, 32'h1c000004, 1); tick();
    drive(0, 1, 0, 0); vld("c2", 1); req("c2", 1, 32'h1c000008, 1); tick();

    // Three-cycle stall holding 0x1c000008
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      vld("stall", 1);
      req("stall", 0, 0, 0);
      check("stall_bus", fs_to_ds_bus, {32'h1c000008, 32'h1c000008});
      tick();
    end
    drive(0, 1, 0, 0); vld("rel", 1); req("rel", 1, 32'h1c00000c, 1); tick();
    drive(0, 1, 0, 0); vld("c7", 1); req("c7", 1, 32'h1c000010, 0); tick();

    // Redirect kills 0x1c000010
    drive(0, 1, 1, 32'h1c000100); vld("br", 0); req("br", 1, 32'h1c000100, 1); tick();
    drive(0, 1, 0, 0); vld("c9", 1); req("c9", 1, 32'h1c000104, 0); tick();

    // Redirect during a buffered stall
    drive(0, 0, 0, 0); vld("c10", 1); req("c10", 0, 0, 0); tick();
    drive(0, 0, 1, 32'h1c000200); vld("brst", 0); req("brst", 1, 32'h1c000200, 1); tick();
    drive(0, 1, 0, 0); vld("c12", 1); req("c12", 1, 32'h1c000204, 0); tick();

    // PC wrap
    drive(0, 1, 1, 32'hfffffffc); vld("brw", 0); req("brw", 1, 32'hfffffffc, 1); tick();
    drive(0, 1, 0, 0); vld("wrap", 1); req("wrap", 1, 32'h00000000, 1); tick();
    drive(0, 1, 0, 0); vld("c15", 1); req("c15", 1, 32'h00000004, 0); tick();

    // Reset mid-stall with a buffered instruction
    drive(0, 0, 0, 0); req("c16", 0, 0, 0); tick();
    drive(1, 0, 0, 0); req("rs0", 0, 0, 0); tick();
    drive(1, 1, 0, 0); vld("rs1", 0); req("rs1", 0, 0, 0);
    check("rs1_pc", {32'b0, fs_to_ds_bus[63:32]}, {32'b0, 32'h1bfffffc});
    tick();
    drive(0, 1, 0, 0); vld("rr0", 0); req("rr0", 1, 32'h1c000000, 1); tick();
    drive(0, 1, 0, 0); vld("rr1", 1); req("rr1", 1, 32'h1c000004, 0); tick();
    drive(0, 0, 0, 0); tick();

    check("sb_left", {32'b0, 32'(sb.size())}, 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage LoongArch pipeline. It owns the PC, issues requests to the synchronous instruction SRAM, and presents {pc, inst} to the decode stage over a valid/allowin handshake. It buffers returned instructions across decode stalls and redirects on branch/jump resolution from decode.

## Interface
Parameters:
- RESET_PC, 32'h1c000000, address of the first fetched instruction after reset.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- ds_allowin  in  1  decode can accept a new instruction this cycle.
- br_bus  in  33  {br_taken[32], br_target[31:0]}; br_taken is a single-cycle pulse from decode.
- fs_to_ds_valid  out  1  fs_to_ds_bus holds a valid instruction.
- fs_to_ds_bus  out  64  {fs_pc[63:32], fs_inst[31:0]}.
- inst_sram_en  out  1  read request strobe.
- inst_sram_we  out  4  tied to 4'b0.
- inst_sram_addr  out  32  request address (= nextpc).
- inst_sram_wdata  out  32  tied to 32'b0.
- inst_sram_rdata  in  32  read data, valid the cycle after an enabled request; undefined otherwise.

## Operation
- State: fs_valid (1b), fs_pc (32b), req_d (1b, "rdata belongs to current fs_pc"), inst_buf (32b), buf_valid (1b).
- seq_pc = fs_pc + 4, modulo 2^32 (wraps 0xfffffffc -> 0x00000000, no flag).
- nextpc = br_taken ? br_target : seq_pc.
- to_fs_valid = ~reset; fs_ready_go = 1.
- fs_allowin = ~fs_valid | (fs_ready_go & ds_allowin) | br_taken.
- inst_sram_en = to_fs_valid & fs_allowin; inst_sram_addr = nextpc always.
- On fs_allowin: fs_valid <= to_fs_valid; fs_pc <= nextpc; req_d <= inst_sram_en.
- Otherwise (stall) fs_valid/fs_pc hold; req_d <= 0.
- fs_inst = buf_valid ? inst_buf : inst_sram_rdata.
- Capture: if fs_valid & req_d & ~ds_allowin & ~br_taken then inst_buf <= inst_sram_rdata, buf_valid <= 1.
- buf_valid clears when fs_valid & ds_allowin (instruction consumed), on br_taken, or on reset.
- fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken.
- Branch: br_taken in any cycle kills the instruction currently in fs (never delivered, not buffered), clears the buffer, and issues a request to br_target that same cycle regardless of ds_allowin. The next cycle fs_valid=1, fs_pc=br_target.
- Unaligned br_target is fetched as given; no exception generated here.

## Timing
- During reset: fs_valid=0, fs_pc=RESET_PC-4, req_d=0, buf_valid=0, inst_buf=0. Outputs: fs_to_ds_valid=0, inst_sram_en=0, fs_to_ds_bus={RESET_PC-4, rdata}, we/wdata=0.
- First cycle after reset deasserts: inst_sram_en=1, addr=RESET_PC. Following cycle: fs_to_ds_valid=1, fs_pc=RESET_PC.
- Request-to-valid latency: 1 cycle. Throughput: 1 instruction/cycle with ds_allowin held high.
- Stall: the first stall cycle captures rdata. Later cycles present inst_buf and issue no request (en=0). Bus contents stay stable until consumed.
- Stall released: the buffered instruction transfers in the cycle ds_allowin=1. A new request to fs_pc+4 is issued in that same cycle.
- br_taken together with ds_allowin=0: branch wins and the stall is ignored for fs.
- br_taken together with ds_allowin=1: the fs instruction is still killed. fs_to_ds_valid=0 that cycle.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values in the next cycle. The pending buffer and redirect are discarded.

## Test plan
- Reset release, ds_allowin=1 constant, SRAM returns addr as data -> addrs 0x1c000000, 0x1c000004, 0x1c000008 on consecutive cycles. Each instruction appears on the bus one cycle later with matching pc.
- Stall: ds_allowin=0 for 3 cycles while fs holds pc 0x1c000008 and the SRAM drives garbage after the first cycle -> bus holds {0x1c000008, 0x1c000008}, en=0 for cycles 2-3. Upon release the instruction is accepted and addr 0x1c00000c is issued.
- Redirect: br_taken pulse, br_target=0x1c000100, fs holding 0x1c000010 -> fs_to_ds_valid=0 that cycle, addr=0x1c000100, next cycle bus pc=0x1c000100. 0x1c000010 is never delivered.
- Redirect during stall: ds_allowin=0 with buf_valid=1, then br_taken with target 0x1c000200 -> buffer dropped, en=1 with addr=0x1c000200 despite the stall, next bus pc=0x1c000200.
- PC wrap: br_target=0xfffffffc, ds_allowin=1 -> subsequent addr 0x00000000.
- Reset mid-stall with buf_valid=1 -> next cycle fs_to_ds_valid=0 and en=0. After release, fetch restarts at RESET_PC.
